// File: rtl/mips_mem_pkg.sv
// Shared definitions for the Harvard CPU memory responder.
//   wait_state_t : data-access wait-state FSM encoding (IDLE, WAIT, READY)
//   WORD_BYTES   : bytes per memory word
//   NOP_WORD     : value returned for faulting or idle reads
//   WAIT_CNT_W   : width of the wait-state down-counter (DATA_WAIT up to 15)
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } wait_state_t;

  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  localparam int          WAIT_CNT_W = 4;

endpackage

// File: rtl/mips_wait_state_gen.sv
// Wait-state generator for data accesses. Holds the CPU with clk_enable=0 for
// exactly DATA_WAIT cycles per access, then grants one enabled cycle.
// With DATA_WAIT=0 the FSM is not built and clk_enable is constant 1.
// Ports:
//   clk        : clock
//   reset      : synchronous, active-high; forces IDLE and clk_enable=1
//   req        : data access pending (read or write)
//   clk_enable : CPU advance qualifier
module mips_wait_state_gen #(
  parameter int DATA_WAIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic clk_enable
);
  import mips_mem_pkg::*;

  generate
    if (DATA_WAIT == 0) begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset, req};
      assign clk_enable    = 1'b1;
    end else begin : g_fsm
      localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(DATA_WAIT - 1);

      wait_state_t           state, state_next;
      logic [WAIT_CNT_W-1:0] cnt, cnt_next;
      logic                  en;

      always_ff @(posedge clk) begin
        if (reset) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          state <= state_next;
          cnt   <= cnt_next;
        end
      end

      always_comb begin
        state_next = state;
        cnt_next   = cnt;
        en         = 1'b1;
        case (state)
          IDLE: begin
            // The stall starts in the same cycle the request appears.
            if (req) begin
              en         = 1'b0;
              cnt_next   = CNT_LOAD;
              state_next = (DATA_WAIT > 1) ? WAIT : READY;
            end
          end
          WAIT: begin
            // Runs to completion even if the request is withdrawn.
            en       = 1'b0;
            cnt_next = cnt - WAIT_CNT_W'(1);
            if (cnt_next == '0) state_next = READY;
          end
          READY:   state_next = IDLE;
          default: state_next = IDLE;
        endcase
        // Reset releases the CPU immediately, abandoning any pending access.
        if (reset) en = 1'b1;
      end

      assign clk_enable = en;
    end
  endgenerate

endmodule

// File: rtl/mips_harvard_mem_responder.sv
// Responder for the Harvard CPU memory interfaces: combinational instruction
// fetch, combinational data read, single-cycle data write, wait-state
// insertion via clk_enable, sticky fault capture, and a preload port that is
// honoured only while reset is asserted. Memory contents survive reset.
// Optional macro MIPS_MEM_ACCESS_COUNT_EN adds rd_count/wr_count outputs.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   instr_address / instr_readdata  : fetch address and word (NOP on fault)
//   data_address, data_read,
//   data_write, data_writedata      : data access request
//   data_readdata                   : load data (0 when not reading / fault)
//   clk_enable                      : CPU advance qualifier
//   load_valid, load_target,
//   load_index, load_data           : preload (target 0 = instr, 1 = data)
//   fault, fault_addr               : sticky fault flag and first fault address
//   rd_count, wr_count              : completed access counters (optional)
// Base addresses are assumed word-aligned, so alignment is checked on the
// base-relative offset.
module mips_harvard_mem_responder #(
  parameter int          INSTR_WORDS = 1024,
  parameter int          DATA_WORDS  = 1024,
  parameter logic [31:0] INSTR_BASE  = 32'h0000_0000,
  parameter logic [31:0] DATA_BASE   = 32'h0000_0000,
  parameter int          DATA_WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  input  logic        load_valid,
  input  logic        load_target,
  input  logic [31:0] load_index,
  input  logic [31:0] load_data,
  output logic        fault,
  output logic [31:0] fault_addr
`ifdef MIPS_MEM_ACCESS_COUNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);
  import mips_mem_pkg::*;

  localparam int BS = $clog2(WORD_BYTES);
  localparam int IW = $clog2(INSTR_WORDS);
  localparam int DW = $clog2(DATA_WORDS);

  logic [31:0] imem [INSTR_WORDS];
  logic [31:0] dmem [DATA_WORDS];

  logic [31:0]   instr_offset, data_offset;
  logic [IW-1:0] instr_idx;
  logic [DW-1:0] data_idx;
  logic          instr_ok, data_ok, data_access;
  logic          instr_fault, data_fault;
  logic          load_i_ok, load_d_ok;
  logic          clk_enable_p1, fault_eval;

  // Address decode: word index plus alignment / range qualification.
  assign instr_offset = instr_address - INSTR_BASE;
  assign data_offset  = data_address - DATA_BASE;
  assign instr_idx    = instr_offset[BS +: IW];
  assign data_idx     = data_offset[BS +: DW];
  assign instr_ok     = (instr_offset[BS-1:0] == '0) && (instr_offset[31:BS+IW] == '0);
  assign data_ok      = (data_offset[BS-1:0] == '0) && (data_offset[31:BS+DW] == '0);
  assign data_access  = data_read | data_write;
  assign instr_fault  = !instr_ok;
  assign data_fault   = data_access && !data_ok;

  assign load_i_ok = (load_index[31:IW] == '0);
  assign load_d_ok = (load_index[31:DW] == '0);

  assign instr_readdata = instr_ok ? imem[instr_idx] : NOP_WORD;
  // With read and write both high, this still shows the pre-write word.
  assign data_readdata  = (data_read && data_ok) ? dmem[data_idx] : NOP_WORD;

  always_ff @(posedge clk) begin
    if (reset && load_valid && !load_target && load_i_ok)
      imem[load_index[IW-1:0]] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (load_valid && load_target && load_d_ok)
        dmem[load_index[DW-1:0]] <= load_data;
    end else if (data_write && clk_enable && data_ok) begin
      dmem[data_idx] <= data_writedata;
    end
  end

  mips_wait_state_gen #(
    .DATA_WAIT (DATA_WAIT)
  ) u_wait (
    .clk        (clk),
    .reset      (reset),
    .req        (data_access),
    .clk_enable (clk_enable)
  );

  // Faults are sampled only outside the interior stall cycles. A cycle with
  // clk_enable=0 that follows an enabled cycle is the FSM's IDLE/request
  // cycle; two consecutive disabled cycles mean the FSM is in WAIT.
  assign fault_eval = clk_enable | clk_enable_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_enable_p1 <= 1'b1;
      fault         <= 1'b0;
      fault_addr    <= '0;
    end else begin
      clk_enable_p1 <= clk_enable;
      if (fault_eval && !fault) begin
        if (data_fault) begin
          fault      <= 1'b1;
          fault_addr <= data_address;
        end else if (instr_fault) begin
          fault      <= 1'b1;
          fault_addr <= instr_address;
        end
      end
    end
  end

`ifdef MIPS_MEM_ACCESS_COUNT_EN
  // An access completes in its enabled cycle; read+write counts as a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (clk_enable) begin
      if (data_write)     wr_count <= wr_count + 32'd1;
      else if (data_read) rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_harvard_mem_responder.sv
module tb_mips_harvard_mem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] instr_address;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic        load_valid;
  logic        load_target;
  logic [31:0] load_index;
  logic [31:0] load_data;

  logic [31:0] ird_w0, ird_w1, ird_w2;
  logic [31:0] drd_w0, drd_w1, drd_w2;
  logic        en_w0, en_w1, en_w2;
  logic        f_w0, f_w1, f_w2;
  logic [31:0] fa_w0, fa_w1, fa_w2;
`ifdef MIPS_MEM_ACCESS_COUNT_EN
  logic [31:0] rdc_w0, rdc_w1, rdc_w2;
  logic [31:0] wrc_w0, wrc_w1, wrc_w2;
`endif

  int checks = 0;
  int passed = 0;

  mips_harvard_mem_responder #(.DATA_WAIT(0)) u_w0 (
    .clk(clk), .reset(reset),
    .instr_address(instr_address), .instr_readdata(ird_w0),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .data_writedata(data_writedata), .data_readdata(drd_w0), .clk_enable(en_w0),
    .load_valid(load_valid), .load_target(load_target), .load_index(load_index),
    .load_data(load_data), .fault(f_w0), .fault_addr(fa_w0)
`ifdef MIPS_MEM_ACCESS_COUNT_EN
    , .rd_count(rdc_w0), .wr_count(wrc_w0)
`endif
  );

  mips_harvard_mem_responder #(.DATA_WAIT(1)) u_w1 (
    .clk(clk), .reset(reset),
    .instr_address(instr_address), .instr_readdata(ird_w1),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .data_writedata(data_writedata), .data_readdata(drd_w1), .clk_enable(en_w1),
    .load_valid(load_valid), .load_target(load_target), .load_index(load_index),
    .load_data(load_data), .fault(f_w1), .fault_addr(fa_w1)
`ifdef MIPS_MEM_ACCESS_COUNT_EN
    , .rd_count(rdc_w1), .wr_count(wrc_w1)
`endif
  );

  mips_harvard_mem_responder #(.DATA_WAIT(2)) u_w2 (
    .clk(clk), .reset(reset),
    .instr_address(instr_address), .instr_readdata(ird_w2),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .data_writedata(data_writedata), .data_readdata(drd_w2), .clk_enable(en_w2),
    .load_valid(load_valid), .load_target(load_target), .load_index(load_index),
    .load_data(load_data), .fault(f_w2), .fault_addr(fa_w2)
`ifdef MIPS_MEM_ACCESS_COUNT_EN
    , .rd_count(rdc_w2), .wr_count(wrc_w2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic preload(input logic tgt, input logic [31:0] idx, input logic [31:0] val);
    load_valid  = 1'b1;
    load_target = tgt;
    load_index  = idx;
    load_data   = val;
    step();
    load_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_address = 32'h0; data_address = 32'h0;
    data_read = 1'b0; data_write = 1'b0; data_writedata = 32'h0;
    load_valid = 1'b0; load_target = 1'b0; load_index = 32'h0; load_data = 32'h0;
    step();
    @(negedge clk);
    checks++; if (en_w2 !== 1'b1) $display("FAIL reset_en_w2: got %b expected 1", en_w2); else passed++;
    checks++; if (en_w0 !== 1'b1) $display("FAIL reset_en_w0: got %b expected 1", en_w0); else passed++;
    checks++; if (f_w2 !== 1'b0) $display("FAIL reset_fault: got %b expected 0", f_w2); else passed++;
    checks++; if (fa_w2 !== 32'h0) $display("FAIL reset_fault_addr: got %h expected 00000000", fa_w2); else passed++;
    preload(1'b0, 32'd0, 32'h24030005);
    preload(1'b0, 32'd2, 32'h00000000);
    preload(1'b1, 32'd4, 32'hDEADBEEF);
    preload(1'b1, 32'd8, 32'h00000000);
    preload(1'b1, 32'd12, 32'hCAFEF00D);
    preload(1'b1, 32'd2000, 32'h0BAD0BAD);
    preload(1'b0, 32'd5000, 32'h0BAD0BAD);
    reset = 1'b0;
    step();
  endtask

  task automatic test_preload_fetch();
    instr_address = 32'h0;
    @(negedge clk);
    checks++; if (ird_w2 !== 32'h24030005) $display("FAIL fetch_0: got %h expected 24030005", ird_w2); else passed++;
    instr_address = 32'h8;
    @(negedge clk);
    checks++; if (ird_w2 !== 32'h0) $display("FAIL fetch_8: got %h expected 00000000", ird_w2); else passed++;
    step();
    instr_address = 32'h0;
    @(negedge clk);
    checks++; if (f_w2 !== 1'b0) $display("FAIL fetch_no_fault: got %b expected 0", f_w2); else passed++;
    // Preload outside reset must be ignored.
    load_valid = 1'b1; load_target = 1'b1; load_index = 32'd4; load_data = 32'h11111111;
    step();
    load_valid = 1'b0;
    data_address = 32'h10; data_read = 1'b1;
    @(negedge clk);
    checks++; if (drd_w0 !== 32'hDEADBEEF) $display("FAIL preload_ignored: got %h expected deadbeef", drd_w0); else passed++;
    checks++; if (f_w0 !== 1'b0) $display("FAIL preload_oor_no_fault: got %b expected 0", f_w0); else passed++;
    step();
    data_read = 1'b0;
    idle(3);
  endtask

  task automatic test_wait_read();
    logic [2:0] pat;
    pat = 3'b100;
    data_address = 32'h10; data_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (en_w2 !== pat[i]) $display("FAIL wait_en[%0d]: got %b expected %b", i, en_w2, pat[i]); else passed++;
      checks++; if (drd_w2 !== 32'hDEADBEEF) $display("FAIL wait_rdata[%0d]: got %h expected deadbeef", i, drd_w2); else passed++;
      step();
    end
    data_read = 1'b0;
    @(negedge clk);
    checks++; if (drd_w2 !== 32'h0) $display("FAIL idle_rdata: got %h expected 00000000", drd_w2); else passed++;
    idle(3);
  endtask

  task automatic test_zero_wait();
    data_address = 32'h20; data_writedata = 32'h12345678; data_write = 1'b1;
    @(negedge clk);
    checks++; if (en_w0 !== 1'b1) $display("FAIL zw_en_write: got %b expected 1", en_w0); else passed++;
    checks++; if (drd_w0 !== 32'h0) $display("FAIL zw_rdata_noread: got %h expected 00000000", drd_w0); else passed++;
    step();
    data_write = 1'b0; data_read = 1'b1;
    @(negedge clk);
    checks++; if (en_w0 !== 1'b1) $display("FAIL zw_en_read: got %b expected 1", en_w0); else passed++;
    checks++; if (drd_w0 !== 32'h12345678) $display("FAIL zw_readback: got %h expected 12345678", drd_w0); else passed++;
    step();
    data_write = 1'b1; data_writedata = 32'hAAAA5555;
    @(negedge clk);
    checks++; if (drd_w0 !== 32'h12345678) $display("FAIL rw_old_word: got %h expected 12345678", drd_w0); else passed++;
    step();
    data_write = 1'b0;
    @(negedge clk);
    checks++; if (drd_w0 !== 32'hAAAA5555) $display("FAIL rw_new_word: got %h expected aaaa5555", drd_w0); else passed++;
    step();
    data_read = 1'b0;
    idle(4);
  endtask

  task automatic test_fault();
    data_address = 32'h22; data_writedata = 32'hFFFFFFFF; data_write = 1'b1;
    step();
    data_write = 1'b0;
    data_address = 32'h20; data_read = 1'b1;
    @(negedge clk);
    checks++; if (f_w0 !== 1'b1) $display("FAIL fault_w0: got %b expected 1", f_w0); else passed++;
    checks++; if (fa_w0 !== 32'h22) $display("FAIL fault_addr_w0: got %h expected 00000022", fa_w0); else passed++;
    checks++; if (fa_w2 !== 32'h22) $display("FAIL fault_addr_w2: got %h expected 00000022", fa_w2); else passed++;
    checks++; if (drd_w0 !== 32'hAAAA5555) $display("FAIL fault_write_dropped: got %h expected aaaa5555", drd_w0); else passed++;
    step();
    data_read = 1'b0;
    instr_address = 32'h0040_0000;
    @(negedge clk);
    checks++; if (ird_w0 !== 32'h0) $display("FAIL fetch_oor_nop: got %h expected 00000000", ird_w0); else passed++;
    step();
    instr_address = 32'h0;
    @(negedge clk);
    checks++; if (fa_w0 !== 32'h22) $display("FAIL fault_sticky_w0: got %h expected 00000022", fa_w0); else passed++;
    checks++; if (f_w2 !== 1'b1) $display("FAIL fault_sticky_flag_w2: got %b expected 1", f_w2); else passed++;
    idle(4);
  endtask

  task automatic test_reset_mid_access();
    logic [2:0] pat;
    pat = 3'b100;
    data_address = 32'h30; data_writedata = 32'h55555555; data_write = 1'b1;
    @(negedge clk);
    checks++; if (en_w2 !== 1'b0) $display("FAIL rma_stall: got %b expected 0", en_w2); else passed++;
    step();
    reset = 1'b1; data_write = 1'b0;
    @(negedge clk);
    checks++; if (en_w2 !== 1'b1) $display("FAIL rma_en_in_reset: got %b expected 1", en_w2); else passed++;
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (en_w2 !== 1'b1) $display("FAIL rma_en_after: got %b expected 1", en_w2); else passed++;
    checks++; if (f_w2 !== 1'b0) $display("FAIL rma_fault_cleared: got %b expected 0", f_w2); else passed++;
    step();
    data_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (en_w2 !== pat[i]) $display("FAIL rma_fresh_wait[%0d]: got %b expected %b", i, en_w2, pat[i]); else passed++;
      if (i == 0) begin
        checks++; if (drd_w2 !== 32'hCAFEF00D) $display("FAIL rma_write_discarded: got %h expected cafef00d", drd_w2); else passed++;
        checks++; if (drd_w0 !== 32'h55555555) $display("FAIL rma_w0_committed: got %h expected 55555555", drd_w0); else passed++;
      end
      step();
    end
    data_read = 1'b0;
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    pat = 6'b100100;
    data_address = 32'h10; data_read = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (en_w2 !== pat[i]) $display("FAIL b2b_en[%0d]: got %b expected %b", i, en_w2, pat[i]); else passed++;
      step();
    end
    data_read = 1'b0;
    idle(4);
  endtask

  task automatic test_counts();
    int  lows;
    bit  seen;
    reset = 1'b1;
    step();
    reset = 1'b0;
`ifdef MIPS_MEM_ACCESS_COUNT_EN
    @(negedge clk);
    checks++; if (rdc_w1 !== 32'h0) $display("FAIL rd_count_reset: got %0d expected 0", rdc_w1); else passed++;
    checks++; if (wrc_w1 !== 32'h0) $display("FAIL wr_count_reset: got %0d expected 0", wrc_w1); else passed++;
`endif
    step();
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        data_address = 32'h10; data_read = 1'b1;
      end else begin
        data_address = 32'h40; data_writedata = k; data_write = 1'b1;
      end
      lows = 0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (en_w1) seen = 1'b1;
        else lows++;
        step();
      end
      data_read = 1'b0; data_write = 1'b0;
      checks++;
      if (!seen || lows != 1) $display("FAIL w1_stall_len[%0d]: got %0d stall cycles expected 1", k, lows);
      else passed++;
      step();
    end
`ifdef MIPS_MEM_ACCESS_COUNT_EN
    @(negedge clk);
    checks++; if (rdc_w1 !== 32'd3) $display("FAIL rd_count: got %0d expected 3", rdc_w1); else passed++;
    checks++; if (wrc_w1 !== 32'd2) $display("FAIL wr_count: got %0d expected 2", wrc_w1); else passed++;
`endif
    data_address = 32'h40; data_read = 1'b1;
    @(negedge clk);
    checks++; if (drd_w1 !== 32'd4) $display("FAIL w1_write_data: got %h expected 00000004", drd_w1); else passed++;
    step();
    data_read = 1'b0;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_preload_fetch();
    test_wait_read();
    test_zero_wait();
    test_fault();
    test_reset_mid_access();
    test_back_to_back();
    test_counts();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mips_harvard_mem_responder.md
Name: mips_harvard_mem_responder

Overview:
Responder end of the Harvard CPU memory interfaces. It serves combinational instruction fetches and combinational data reads, and commits data writes in a single cycle. It inserts a configurable number of wait states on data accesses by driving the CPU's clk_enable. It sits beside the CPU in the system top level, replaces the bench memory model, and provides a preload port that is active while the CPU is held in reset.

Parameters:
INSTR_WORDS, 1024, instruction memory depth in 32-bit words (power of two)
DATA_WORDS, 1024, data memory depth in 32-bit words (power of two)
INSTR_BASE, 32'h00000000, byte address of instruction word 0
DATA_BASE, 32'h00000000, byte address of data word 0
DATA_WAIT, 2, stall cycles per data access (0..15); 0 means no stall

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
instr_address  in  32  byte address of the fetch
instr_readdata  out  32  fetched word (combinational)
data_address  in  32  byte address of the data access
data_read  in  1  load request
data_write  in  1  store request
data_writedata  in  32  store data
data_readdata  out  32  load data (combinational)
clk_enable  out  1  CPU advance qualifier
load_valid  in  1  preload strobe
load_target  in  1  0 = instruction memory, 1 = data memory
load_index  in  32  preload word index
load_data  in  32  preload word
fault  out  1  sticky access fault
fault_addr  out  32  byte address of the first fault

Behaviour:
- Reset values:
  - clk_enable=1, fault=0, fault_addr=0, FSM=IDLE, wait counter=0.
  - Memory contents are NOT cleared by reset.
- Instruction port, purely combinational:
  - Word index = (instr_address - INSTR_BASE) >> 2.
  - A misaligned address (bits [1:0] != 0) or an out-of-range index returns 32'h0 (NOP) and raises fault.
- Data read, combinational:
  - When data_read=1, data_readdata returns the word at (data_address - DATA_BASE) >> 2; otherwise it returns 0.
  - A misaligned or out-of-range read returns 0 and raises fault.
- Data write:
  - Commits at the posedge where data_write=1, clk_enable=1 and reset=0.
  - A misaligned or out-of-range write is dropped and raises fault.
- data_read and data_write both high: treated as a write, and data_readdata returns the old word.
- Wait-state FSM (states IDLE, WAIT, READY), active only when DATA_WAIT>0:
  - IDLE, no access: clk_enable=1.
  - IDLE, access seen (data_read|data_write): clk_enable=0 combinationally, counter loads DATA_WAIT-1. Next state is WAIT if DATA_WAIT>1, else READY.
  - WAIT: clk_enable=0, counter decrements. Go to READY when the counter reaches 0 after decrement.
  - READY: clk_enable=1. The write commits at this edge, then the FSM returns to IDLE.
  - Net effect: exactly DATA_WAIT cycles with clk_enable=0, followed by one enabled cycle, per access.
  - Back-to-back accesses each pay the full DATA_WAIT.
- DATA_WAIT=0: FSM bypassed, clk_enable tied to 1.
- Request drops during WAIT (protocol violation): the FSM still completes to READY, and no write commits because data_write=0.
- Reset mid-access: the FSM forces IDLE, clk_enable=1, and the pending write is discarded.
- fault and fault_addr:
  - fault is sticky; fault_addr captures the first faulting address (data has priority over instruction if both fault in the same cycle).
  - Only reset clears them.
  - fault is evaluated only in cycles where clk_enable=1 or the FSM is in IDLE.
- Preload:
  - load_valid is honoured only while reset=1; ignored otherwise.
  - An out-of-range load_index is ignored silently, with no fault.
  - Preload writes at the posedge.

Optional Feature:
MIPS_MEM_ACCESS_COUNT_EN:
- Defined: adds output ports rd_count (32) and wr_count (32).
  - Each counts data accesses completed in an enabled cycle; faulting accesses are counted too.
  - Both reset to 0 and wrap from 32'hFFFFFFFF to 0.
- Undefined: the ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package mips_mem_pkg holds:
  - the wait-state enum (IDLE, WAIT, READY);
  - WORD_BYTES=4;
  - NOP_WORD=32'h0;
  - the wait-counter width constant (4 bits).
- Sub-module mips_wait_state_gen contains the FSM and counter.
  - Inputs: clk, reset, req.
  - Output: clk_enable.
  - Parameter: DATA_WAIT.
- Memory arrays, decode and fault logic stay in the top level.

Test Plan:
1. Preload under reset, instr word 0 = 32'h24030005, then release reset → instr_address=0 returns 32'h24030005; instr_address=8 (unloaded) returns the preloaded value or 0; fault=0.
2. DATA_WAIT=2, data_read at address 0x10 holding 32'hDEADBEEF → clk_enable low for exactly 2 cycles, high on the 3rd; data_readdata=32'hDEADBEEF throughout.
3. DATA_WAIT=0, data_write of 32'h12345678 to 0x20, then data_read of 0x20 next cycle → clk_enable stays 1; the read returns 32'h12345678.
4. data_write to misaligned address 0x22 → memory unchanged, fault=1, fault_addr=32'h22; a later fault at 0x400000 leaves fault_addr=32'h22.
5. Assert reset during the first WAIT cycle of a write to 0x30 → clk_enable=1 next cycle, word at 0x30 unchanged, FSM in IDLE.
6. With MIPS_MEM_ACCESS_COUNT_EN: 3 reads and 2 writes (DATA_WAIT=1) → rd_count=3, wr_count=2; each counter increments once per access, not once per stall cycle.
